// File: rtl/ising_gpio_cfg_regfile.sv
// GPIO-driven configuration register file: synchronises PS write words, commits one table write per
// write-clock rising edge into NUM_BANKS lookup tables. Optional readback echo: CFG_READBACK_EN.
module ising_gpio_cfg_regfile #(
    parameter int          GPIO_W      = 32,
    parameter int          W_CLK_BIT   = 24,
    parameter int          ADDR_LSB    = 0,
    parameter int          ADDR_W      = 16,
    parameter int          DATA_LSB    = 16,
    parameter int          DATA_W      = 8,
    parameter int          NUM_BANKS   = 2,
    parameter int          BANK_STRIDE = 256,
    parameter int          BANK_DEPTH  = 256,
    parameter logic [15:0] CLR_ADDR    = 16'hFFFF,
    localparam int         BANK_AW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int         IDX_W       = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GPIO_W-1:0]             gpio_in,
    input  logic [NUM_BANKS*IDX_W-1:0]    rd_idx,
    output logic [NUM_BANKS*DATA_W-1:0]   rd_data,
    output logic                          wr_stb,
    output logic [BANK_AW-1:0]            wr_bank,
    output logic [IDX_W-1:0]              wr_idx,
    output logic [15:0]                   wr_count,
    output logic                          err_addr,
    output logic [GPIO_W-1:0]             gpio_out
);

    logic [GPIO_W-1:0] s1, s2;
    logic              s3_clk;
    logic              wclk_rise;

    logic [ADDR_W-1:0] cur_a;
    logic [DATA_W-1:0] cur_d;
    logic [31:0]       cur_q, cur_r;
    logic              cur_err;

    logic              dec_vld;
    logic              dec_clr;
    logic              dec_err;
    logic [BANK_AW-1:0] dec_bank;
    logic [IDX_W-1:0]  dec_idx;
    logic [DATA_W-1:0] dec_d;

    logic [DATA_W-1:0] mem [NUM_BANKS][BANK_DEPTH];

    // Only the write clock bit needs edge history; the rest of s2 is stable around the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            s3_clk <= 1'b0;
        end else begin
            s1     <= gpio_in;
            s2     <= s1;
            s3_clk <= s2[W_CLK_BIT];
        end
    end

    assign wclk_rise = s2[W_CLK_BIT] & ~s3_clk;

    // Division/modulo keeps decode correct for non-power-of-two strides.
    always_comb begin
        cur_a   = s2[ADDR_LSB +: ADDR_W];
        cur_d   = s2[DATA_LSB +: DATA_W];
        cur_q   = 32'(cur_a) / 32'(BANK_STRIDE);
        cur_r   = 32'(cur_a) % 32'(BANK_STRIDE);
        cur_err = (cur_q >= 32'(NUM_BANKS)) || (cur_r >= 32'(BANK_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_vld  <= 1'b0;
            dec_clr  <= 1'b0;
            dec_err  <= 1'b0;
            dec_bank <= '0;
            dec_idx  <= '0;
            dec_d    <= '0;
        end else begin
            dec_vld  <= wclk_rise;
            dec_clr  <= (32'(cur_a) == 32'(CLR_ADDR));
            dec_err  <= cur_err;
            dec_bank <= cur_q[BANK_AW-1:0];
            dec_idx  <= cur_r[IDX_W-1:0];
            dec_d    <= cur_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_stb   <= 1'b0;
            wr_bank  <= '0;
            wr_idx   <= '0;
            wr_count <= '0;
            err_addr <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++)
                for (int i = 0; i < BANK_DEPTH; i++)
                    mem[b][i] <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (dec_vld) begin
                if (dec_clr) begin
                    wr_count <= '0;
                    err_addr <= 1'b0;
                end else if (dec_err) begin
                    err_addr <= 1'b1;
                end else begin
                    mem[dec_bank][dec_idx] <= dec_d;
                    wr_stb  <= 1'b1;
                    wr_bank <= dec_bank;
                    wr_idx  <= dec_idx;
                    if (wr_count != 16'hFFFF)
                        wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

    // A same-cycle commit to the read entry is not visible until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (32'(rd_idx[b*IDX_W +: IDX_W]) < 32'(BANK_DEPTH))
                    rd_data[b*DATA_W +: DATA_W] <= mem[b][rd_idx[b*IDX_W +: IDX_W]];
                else
                    rd_data[b*DATA_W +: DATA_W] <= '0;
            end
        end
    end

`ifdef CFG_READBACK_EN
    logic [ADDR_W-1:0] dec_a;
    logic              rb_vld;
    logic [ADDR_W-1:0] rb_a;
    logic [DATA_W-1:0] rb_d;
    logic [GPIO_W-1:0] rb_word;

    always_ff @(posedge clk) begin
        if (rst) dec_a <= '0;
        else     dec_a <= cur_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_vld <= 1'b0;
            rb_a   <= '0;
            rb_d   <= '0;
        end else begin
            rb_vld <= dec_vld;
            rb_a   <= dec_a;
            rb_d   <= (dec_clr || dec_err) ? '0 : dec_d;
        end
    end

    // err_addr has already settled from the decision when the echo is formed.
    always_comb begin
        rb_word                       = '0;
        rb_word[DATA_LSB +: DATA_W]   = rb_d;
        rb_word[ADDR_LSB +: ADDR_W]   = rb_a;
        rb_word[W_CLK_BIT]            = err_addr;
    end

    always_ff @(posedge clk) begin
        if (rst)         gpio_out <= '0;
        else if (rb_vld) gpio_out <= rb_word;
    end
`else
    assign gpio_out = '0;
`endif

endmodule

// File: doc/ising_gpio_cfg_regfile.md
Name: ising_gpio_cfg_regfile

Overview:
- Parametrised successor to the fixed GPIO configuration map: decodes PS-driven GPIO write words into NUM_BANKS on-chip lookup tables, for example the MAC input scaler bank and the NL input scaler bank.
- Synchronises the GPIO write clock bit, detects its rising edge and performs one table write per edge.
- Exposes one registered read port per bank to the Ising datapath.
- Adds range checking, a write counter and a clear command.

Parameters:
- GPIO_W, 32, GPIO word width.
- W_CLK_BIT, 24, bit index of the GPIO write clock.
- ADDR_LSB, 0, LSB of the address field.
- ADDR_W, 16, address field width.
- DATA_LSB, 16, LSB of the data field.
- DATA_W, 8, table entry width (num_bits).
- NUM_BANKS, 2, number of tables.
- BANK_STRIDE, 256, address span per bank; bank b base address is b*BANK_STRIDE.
- BANK_DEPTH, 256, implemented entries per bank; must be <= BANK_STRIDE.
- CLR_ADDR, 16'hFFFF, command address that clears status.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- gpio_in  in  GPIO_W  PS GPIO word, asynchronous to clk.
- rd_idx  in  NUM_BANKS*$clog2(BANK_DEPTH)  per-bank read index, flattened with bank 0 at the LSBs.
- rd_data  out  NUM_BANKS*DATA_W  per-bank registered read data, flattened.
- wr_stb  out  1  single-cycle pulse when a table write commits.
- wr_bank  out  $clog2(NUM_BANKS)  bank of the committed write.
- wr_idx  out  $clog2(BANK_DEPTH)  index of the committed write.
- wr_count  out  16  accepted-write counter, saturating.
- err_addr  out  1  sticky out-of-range address flag.
- gpio_out  out  GPIO_W  readback word (see Optional Feature).

Behaviour:
- Reset (rst=1 at clk edge):
  - all table entries, rd_data, wr_stb, wr_bank, wr_idx, wr_count, err_addr, gpio_out and the sync flops go to 0.
  - rst takes priority over any in-flight write; a write whose edge is pending during rst is discarded.
- Sync pipeline:
  - the whole gpio_in word passes through 2 flops (s1, s2); s3 holds the previous s2 write clock bit.
  - edge = s2[W_CLK_BIT] & ~s3[W_CLK_BIT].
  - The PS must hold addr/data stable >=3 clk before raising the write clock bit and while it is high.
- Decode, registered in the edge cycle:
  - a = s2[ADDR_LSB +: ADDR_W], d = s2[DATA_LSB +: DATA_W]
  - bank = a / BANK_STRIDE, idx = a % BANK_STRIDE.
- Commit, on the clk edge after the edge cycle:
  - if a == CLR_ADDR: wr_count<=0 and err_addr<=0; no table write; wr_stb stays low.
  - else if bank >= NUM_BANKS or idx >= BANK_DEPTH: err_addr<=1; no table write; wr_stb stays low; wr_count unchanged.
  - else: table[bank][idx]<=d; wr_stb=1 for one cycle; wr_bank and wr_idx updated and held until the next commit; wr_count increments, saturating at 16'hFFFF.
- Latency: the commit occurs on clk edge 4, counting the first clk edge that samples the write clock bit at 1 as edge 1.
- Write clock held high: exactly one write. Falling edge: no action.
- Back-to-back GPIO toggles: each rising edge commits independently. The minimum toggle period is 2 clk; faster toggles may be merged by the synchroniser and are not guaranteed.
- Reads:
  - rd_data[b] <= table[b][rd_idx[b]] every cycle, 1-cycle latency, all banks independent.
  - Same-cycle read and commit to the same entry returns the old value; the new value appears on the following read.
- Arithmetic:
  - bank and idx are computed by division and modulo when BANK_STRIDE is not a power of two; the implementation must be correct for any BANK_STRIDE.
  - Indices are zero-extended.

Optional Feature:
- Macro: CFG_READBACK_EN.
- Defined: one cycle after each commit or error decision, gpio_out <= {status, echo}:
  - gpio_out[DATA_LSB +: DATA_W] = stored data, or 0 on error/clear;
  - gpio_out[ADDR_LSB +: ADDR_W] = a;
  - gpio_out[W_CLK_BIT] = err_addr.
  - The PS uses this to confirm writes.
- Undefined: gpio_out is tied to 0 and no readback logic is built.

Test Plan:
- Reset, then rd_idx=0/0 -> rd_data=0 for both banks; wr_count=0; err_addr=0.
- GPIO write addr=5, data=8'hA7 via a write clock bit toggle -> wr_stb pulse on edge 4 with wr_bank=0, wr_idx=5; next cycle, rd_idx[0]=5 gives 8'hA7; wr_count=1.
- Write addr=256+255, data=8'h3C -> table[1][255]=8'h3C; table[0][255] unchanged.
- Write addr=600 with NUM_BANKS=2 -> err_addr=1, no wr_stb, wr_count unchanged. Then write addr=16'hFFFF -> err_addr=0, wr_count=0.
- Hold the write clock bit high for 20 cycles -> one commit only. Assert rst 1 cycle after the edge -> no commit; table remains 0.
- With CFG_READBACK_EN defined, write addr=7, data=8'h11 -> gpio_out = {err=0, data=8'h11, addr=16'd7} one cycle after wr_stb. Repeat without the macro -> gpio_out stays 0.
